mcp3008_responder: RTL and testbench

Synthesizable SPI responder that emulates an MCP3008 10-bit ADC on the slave side of the same 4-wire bus our `mcp3008_adc` initiator drives. It answers conversion requests with samples held in an internal 8-channel sample table that the design loads through a valid/data port. Its purposes are:
- closed-loop, board-level and simulation testing of the ADC front end, minmax trigger and filter chain without analog hardware;
- replaying recorded data, for example data read back from the SD card.

---
 rtl/mcp3008_pkg.sv | 17 +
 rtl/mcp3008_responder_sync_edge_detect.sv | 31 +++
 rtl/mcp3008_responder.sv | 123 ++++++++++++
 tb/tb_mcp3008_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mcp3008_pkg.sv
// rtl/mcp3008_pkg.sv - shared MCP3008 constants and responder state encoding
package mcp3008_pkg;

    localparam int MCP3008_ADDR_BITS = 4;
    localparam int MCP3008_DATA_BITS = 10;
    localparam int MCP3008_CHANNELS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        ADDR,
        NULL,
        DATA,
        TRAIL
    } responder_state_t;

endpackage

// File: rtl/mcp3008_responder_sync_edge_detect.sv
// rtl/mcp3008_responder_sync_edge_detect.sv - input synchronizer with rise/fall detection
module sync_edge_detect #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [DEPTH-1:0] sync_q;
    logic             prev_q;

    // Chain resets low so a chip select already low at reset release never looks like a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
            prev_q <= sync_q[DEPTH-1];
        end
    end

    assign level_o = sync_q[DEPTH-1];
    assign rise_o  = sync_q[DEPTH-1] & ~prev_q;
    assign fall_o  = ~sync_q[DEPTH-1] & prev_q;

endmodule

// File: rtl/mcp3008_responder.sv
// rtl/mcp3008_responder.sv - SPI slave emulating an MCP3008 ADC from a loadable sample table
module mcp3008_responder
    import mcp3008_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = MCP3008_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_cs_n,
    input  logic                 spi_clk,
    input  logic                 spi_din,
    output logic                 spi_dout,
    input  logic                 sample_valid,
    input  logic [2:0]           sample_channel,
    input  logic [DATA_BITS-1:0] sample_data,
    output logic                 conv_valid,
    output logic [2:0]           conv_channel,
    output logic                 conv_single,
    output logic                 frame_error
);

    logic cs_level, cs_fall, sclk_rise, sclk_fall, din_level;

    sync_edge_detect #(.DEPTH(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d_i(spi_cs_n),
        .level_o(cs_level), .rise_o(), .fall_o(cs_fall)
    );

    sync_edge_detect #(.DEPTH(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(spi_clk),
        .level_o(), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    sync_edge_detect #(.DEPTH(SYNC_STAGES)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .d_i(spi_din),
        .level_o(din_level), .rise_o(), .fall_o()
    );

    logic [DATA_BITS-1:0] table_q [MCP3008_CHANNELS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MCP3008_CHANNELS; i++) table_q[i] <= '0;
        end else if (sample_valid) begin
            table_q[sample_channel] <= sample_data;
        end
    end

    responder_state_t     state_q;
    logic [3:0]           bit_cnt_q;
    logic [2:0]           addr_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 dout_q, conv_valid_q, conv_single_q, frame_error_q;
    logic [2:0]           conv_channel_q;

    // addr_q collects {SGL, D2, D1}; D0 is taken straight from the pin on the final rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            addr_q         <= '0;
            shift_q        <= '0;
            dout_q         <= 1'b0;
            conv_valid_q   <= 1'b0;
            conv_channel_q <= '0;
            conv_single_q  <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            conv_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            if (cs_level) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                dout_q    <= 1'b0;
                if (state_q == ADDR || state_q == NULL || state_q == DATA)
                    frame_error_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (cs_fall) begin
                        state_q   <= WAIT_START;
                        bit_cnt_q <= '0;
                    end
                    WAIT_START: if (sclk_rise && din_level) begin
                        state_q   <= ADDR;
                        bit_cnt_q <= '0;
                    end
                    ADDR: if (sclk_rise) begin
                        addr_q    <= {addr_q[1:0], din_level};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(MCP3008_ADDR_BITS - 1)) begin
                            shift_q        <= table_q[{addr_q[1:0], din_level}];
                            conv_valid_q   <= 1'b1;
                            conv_channel_q <= {addr_q[1:0], din_level};
                            conv_single_q  <= addr_q[2];
                            state_q        <= NULL;
                        end
                    end
                    NULL: if (sclk_fall) begin
                        dout_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                    DATA: if (sclk_fall) begin
                        dout_q    <= shift_q[DATA_BITS-1];
                        shift_q   <= {shift_q[DATA_BITS-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) state_q <= TRAIL;
                    end
                    TRAIL: if (sclk_fall) dout_q <= 1'b0;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign spi_dout     = dout_q;
    assign conv_valid   = conv_valid_q;
    assign conv_channel = conv_channel_q;
    assign conv_single  = conv_single_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_mcp3008_responder.sv
// tb/tb_mcp3008_responder.sv - randomized self-checking bench for mcp3008_responder
module tb_mcp3008_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_din = 1'b0;
    logic       spi_dout;
    logic       sample_valid = 1'b0;
    logic [2:0] sample_channel = '0;
    logic [9:0] sample_data = '0;
    logic       conv_valid;
    logic [2:0] conv_channel;
    logic       conv_single;
    logic       frame_error;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] model [8];
    int conv_hi = 0, conv_pulses = 0, fe_cnt = 0;
    logic conv_prev = 1'b0;

    mcp3008_responder #(.SYNC_STAGES(2), .DATA_BITS(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_din(spi_din), .spi_dout(spi_dout),
        .sample_valid(sample_valid), .sample_channel(sample_channel), .sample_data(sample_data),
        .conv_valid(conv_valid), .conv_channel(conv_channel), .conv_single(conv_single),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (conv_valid) begin
            conv_hi++;
            if (!conv_prev) conv_pulses++;
        end
        conv_prev = conv_valid;
        if (frame_error) fe_cnt++;
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_table(input logic [2:0] ch, input logic [9:0] val);
        sample_valid = 1'b1; sample_channel = ch; sample_data = val;
        tick();
        sample_valid = 1'b0;
        model[ch] = val;
    endtask

    // One SCLK period (mode 0): low half then high half; MISO sampled just before the rise.
    task automatic spi_period(input logic din_v, input logic collide, input logic [2:0] wch,
                              input logic [9:0] wval, output logic miso);
        spi_clk = 1'b0; spi_din = din_v;
        repeat (8) tick();
        miso = spi_dout;
        spi_clk = 1'b1;
        if (collide) begin
            repeat (2) tick();
            sample_valid = 1'b1; sample_channel = wch; sample_data = wval;
            tick();
            sample_valid = 1'b0;
            repeat (5) tick();
        end else begin
            repeat (8) tick();
        end
    endtask

    task automatic send_header(input int lead, input logic sgl, input logic [2:0] ch,
                               input logic collide, input logic [9:0] cval);
        logic m;
        spi_clk = 1'b0; spi_cs_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < lead; i++) spi_period(1'b0, 1'b0, 3'd0, 10'd0, m);
        spi_period(1'b1, 1'b0, 3'd0, 10'd0, m);
        spi_period(sgl, 1'b0, 3'd0, 10'd0, m);
        spi_period(ch[2], 1'b0, 3'd0, 10'd0, m);
        spi_period(ch[1], 1'b0, 3'd0, 10'd0, m);
        spi_period(ch[0], collide, ch, cval, m);
    endtask

    task automatic run_frame(input string tag, input int lead, input logic sgl, input logic [2:0] ch,
                             input logic collide, input logic [9:0] cval);
        logic [9:0] exp, word;
        logic m, trail_or;
        int c0, h0, f0;
        exp = model[ch];
        c0 = conv_pulses; h0 = conv_hi; f0 = fe_cnt;
        send_header(lead, sgl, ch, collide, cval);
        if (collide) model[ch] = cval;
        spi_period(1'b0, 1'b0, 3'd0, 10'd0, m);
        expect_eq({tag, " null"}, 32'(m), 32'd0);
        word = '0;
        for (int i = 0; i < 10; i++) begin
            spi_period(1'b0, 1'b0, 3'd0, 10'd0, m);
            word = {word[8:0], m};
        end
        expect_eq({tag, " data"}, 32'(word), 32'(exp));
        trail_or = 1'b0;
        for (int i = 0; i < 2; i++) begin
            spi_period(1'b0, 1'b0, 3'd0, 10'd0, m);
            trail_or |= m;
        end
        expect_eq({tag, " trail"}, 32'(trail_or), 32'd0);
        spi_clk = 1'b0;
        repeat (8) tick();
        spi_cs_n = 1'b1;
        repeat (6) tick();
        expect_eq({tag, " conv_pulses"}, 32'(conv_pulses - c0), 32'd1);
        expect_eq({tag, " conv_width"}, 32'(conv_hi - h0), 32'd1);
        expect_eq({tag, " conv_channel"}, 32'(conv_channel), 32'(ch));
        expect_eq({tag, " conv_single"}, 32'(conv_single), 32'(sgl));
        expect_eq({tag, " frame_error"}, 32'(fe_cnt - f0), 32'd0);
        expect_eq({tag, " idle_dout"}, 32'(spi_dout), 32'd0);
    endtask

    initial begin
        logic m;
        int c0, f0;
        for (int i = 0; i < 8; i++) model[i] = '0;

        repeat (3) tick();
        expect_eq("reset_outputs", 32'({spi_dout, conv_valid, conv_channel, conv_single, frame_error}), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        write_table(3'd3, 10'h2A5);
        run_frame("basic", 0, 1'b1, 3'd3, 1'b0, 10'd0);

        write_table(3'd7, 10'h3FF);
        run_frame("lead_zeros", 5, 1'b1, 3'd7, 1'b0, 10'd0);

        write_table(3'd0, 10'h001);
        f0 = fe_cnt;
        send_header(0, 1'b1, 3'd0, 1'b0, 10'd0);
        for (int i = 0; i < 4; i++) spi_period(1'b0, 1'b0, 3'd0, 10'd0, m);
        spi_cs_n = 1'b1;
        repeat (6) tick();
        expect_eq("abort frame_error", 32'(fe_cnt - f0), 32'd1);
        expect_eq("abort dout", 32'(spi_dout), 32'd0);
        spi_clk = 1'b0;
        repeat (6) tick();
        run_frame("after_abort", 0, 1'b1, 3'd0, 1'b0, 10'd0);

        write_table(3'd2, 10'h155);
        run_frame("collision", 0, 1'b1, 3'd2, 1'b1, 10'h0AA);
        run_frame("post_collision", 0, 1'b0, 3'd2, 1'b0, 10'd0);

        write_table(3'd5, 10'h2C3);
        send_header(0, 1'b1, 3'd5, 1'b0, 10'd0);
        for (int i = 0; i < 4; i++) spi_period(1'b0, 1'b0, 3'd0, 10'd0, m);
        spi_clk = 1'b0;
        repeat (5) tick();
        expect_eq("pre_reset dout", 32'(spi_dout), 32'(model[5][6]));
        rst_n = 1'b0;
        #1;
        expect_eq("midreset_outputs", 32'({spi_dout, conv_valid, conv_channel, conv_single, frame_error}), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = '0;
        c0 = conv_pulses;
        for (int i = 0; i < 6; i++) spi_period(1'b1, 1'b0, 3'd0, 10'd0, m);
        expect_eq("stale_frame_ignored", 32'(conv_pulses - c0), 32'd0);
        spi_clk = 1'b0;
        tick();
        spi_cs_n = 1'b1;
        repeat (6) tick();
        run_frame("after_reset", 0, 1'b1, 3'd5, 1'b0, 10'd0);

        for (int n = 0; n < 20; n++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                write_table(3'($urandom_range(0, 7)), 10'($urandom));
            run_frame("random", $urandom_range(0, 3), 1'($urandom), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0), 10'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
